// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared states and constants for the RAM arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic       M0      = 1'b0;
    localparam logic       M1      = 1'b1;
    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-request round-robin arbiter
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == M1) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= M1;
        end else if (update_i) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one word RAM between two masters with byte-enable RMW
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    state_t            state_q;
    logic              owner_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              m0_rvalid_q, m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    logic [1:0]        arb_gnt;
    logic              grant_en;
    logic              sel;
    logic              sel_we;
    logic [BE_W-1:0]   sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] merged_d;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({m1_req_i, m0_req_i}),
        .update_i (grant_en),
        .gnt_o    (arb_gnt)
    );

    assign grant_en  = (state_q == ST_IDLE) && !rst && (arb_gnt != 2'b00);
    assign m0_gnt_o  = grant_en && arb_gnt[0];
    assign m1_gnt_o  = grant_en && arb_gnt[1];

    assign sel       = arb_gnt[1];
    assign sel_we    = sel ? m1_we_i    : m0_we_i;
    assign sel_be    = sel ? m1_be_i    : m0_be_i;
    assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;

    always_comb begin
        merged_d = '0;
        for (int i = 0; i < BE_W; i++) begin
            merged_d[i*8 +: 8] = be_q[i] ? wdata_q[i*8 +: 8] : ram_rdata_i[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= M0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            ram_we_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_en) begin
                        owner_q <= sel;
                        we_q    <= sel_we;
                        be_q    <= sel_be;
                        wdata_q <= sel_wdata;
                        if (sel_we && (sel_be == '0)) begin
                            state_q <= ST_RESP;
                            if (sel == M0) begin
                                m0_rvalid_q <= 1'b1;
                                m0_rdata_q  <= '0;
                            end else begin
                                m1_rvalid_q <= 1'b1;
                                m1_rdata_q  <= '0;
                            end
                        end else begin
                            // RAM address is registered here so the read port is valid in RD.
                            ram_addr_q <= sel_addr & ~ADDR_W'(3);
                            if (sel_we && (sel_be == {BE_W{1'b1}})) begin
                                ram_we_q    <= 1'b1;
                                ram_wdata_q <= sel_wdata;
                                state_q     <= ST_WR;
                            end else begin
                                state_q <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        ram_we_q    <= 1'b1;
                        ram_wdata_q <= merged_d;
                        state_q     <= ST_WR;
                    end else begin
                        state_q <= ST_RESP;
                        if (owner_q == M0) begin
                            m0_rvalid_q <= 1'b1;
                            m0_rdata_q  <= ram_rdata_i;
                        end else begin
                            m1_rvalid_q <= 1'b1;
                            m1_rdata_q  <= ram_rdata_i;
                        end
                    end
                end
                ST_WR: begin
                    state_q <= ST_RESP;
                    if (owner_q == M0) begin
                        m0_rvalid_q <= 1'b1;
                        m0_rdata_q  <= '0;
                    end else begin
                        m1_rvalid_q <= 1'b1;
                        m1_rdata_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    assign ram_rdata_i = mem[ram_addr_o[7:2]];
    always @(posedge clk) if (ram_we_o) mem[ram_addr_o[7:2]] <= ram_wdata_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wdata;
        end else begin
            m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wdata;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {63'd0, |{m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o,
                          m1_rdata_o, ram_we_o, ram_addr_o, ram_wdata_o}}, 64'd0);
    endtask

    // Called at 2 time units after a rising edge; returns at the same phase.
    task automatic txn(input string tag, input bit m, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input int exp_nw,
                       input logic [31:0] exp_ram_addr, input logic [31:0] exp_wdata);
        bit got, other;
        int lat, nw;
        logic [31:0] waddr, wd, a1, rd;
        got = 0; other = 0; nw = 0; waddr = '0; wd = '0; rd = '0;
        drive(m, 1'b1, we, be, addr, wdata);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m ? m1_gnt_o : m0_gnt_o) begin
                got = 1;
                break;
            end
            @(posedge clk); #2;
        end
        chk({tag, "_gnt"}, 64'(got), 64'd1);
        if (!got) begin
            drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            return;
        end
        chk({tag, "_xgnt"}, 64'(m ? m0_gnt_o : m1_gnt_o), 64'd0);
        @(posedge clk); #2;
        drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = 1;
        a1 = ram_addr_o;
        for (int i = 0; i < 10; i++) begin
            if (ram_we_o) begin
                nw++; waddr = ram_addr_o; wd = ram_wdata_o;
            end
            if (m ? m0_rvalid_o : m1_rvalid_o) other = 1;
            if (m ? m1_rvalid_o : m0_rvalid_o) begin
                rd = m ? m1_rdata_o : m0_rdata_o;
                break;
            end
            @(posedge clk); #2;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_rdata"}, 64'(rd), 64'(exp_rdata));
        chk({tag, "_nwrites"}, 64'(nw), 64'(exp_nw));
        chk({tag, "_ramaddr"}, 64'(a1), 64'(exp_ram_addr));
        chk({tag, "_other_rvalid"}, 64'(other), 64'd0);
        if (exp_nw > 0) begin
            chk({tag, "_waddr"}, 64'(waddr), 64'(exp_ram_addr));
            chk({tag, "_wdata"}, 64'(wd), 64'(exp_wdata));
        end
        @(posedge clk); #2;
        chk({tag, "_rvalid_drop"}, 64'(m ? m1_rvalid_o : m0_rvalid_o), 64'd0);
    endtask

    int gcyc [$];
    int gmst [$];
    int overlap;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'hDEADBEEF;
        mem[32'h30 >> 2] = 32'hCAFEF00D;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #2;
        chk_all_zero("post_reset_outputs");

        txn("rd_after_reset", 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 32'h10, 32'h0);
        txn("full_write",     1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678, 2, 32'h0, 1, 32'h20, 32'h12345678);
        txn("readback",       1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 2, 32'h12345678, 0, 32'h20, 32'h0);
        txn("partial_rmw",    1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 3, 32'h0, 1, 32'h20, 32'h12BB56DD);
        txn("unaligned_rd",   1'b0, 1'b0, 4'h0, 32'h23, 32'h0, 2, 32'h12BB56DD, 0, 32'h20, 32'h0);
        txn("be_zero_write",  1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 1, 32'h0, 0, 32'h20, 32'h0);
        txn("be_zero_check",  1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 2, 32'hCAFEF00D, 0, 32'h30, 32'h0);

        // Contention: both masters read continuously after a fresh reset.
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
        overlap = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m0_gnt_o) begin gcyc.push_back(c); gmst.push_back(0); end
            if (m1_gnt_o) begin gcyc.push_back(c); gmst.push_back(1); end
            if (m0_rvalid_o && m1_rvalid_o) overlap++;
            @(posedge clk); #2;
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("contend_ngrants", 64'(gcyc.size()), 64'd4);
        if (gcyc.size() == 4) begin
            chk("contend_order", {60'd0, gmst[0][0], gmst[1][0], gmst[2][0], gmst[3][0]}, 64'b0101);
            chk("contend_cycles", {gcyc[0][15:0], gcyc[1][15:0], gcyc[2][15:0], gcyc[3][15:0]},
                {16'd0, 16'd3, 16'd6, 16'd9});
        end
        chk("contend_overlap", 64'(overlap), 64'd0);
        repeat (3) @(posedge clk);
        #2;

        // Reset during the RD phase of a partial write aborts it.
        drive(1'b1, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h11112222);
        #1;
        chk("abort_gnt", 64'(m1_gnt_o), 64'd1);
        @(posedge clk); #2;
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("abort_rd_nowe", 64'(ram_we_o), 64'd0);
        rst = 1'b1;
        @(posedge clk); #2;
        chk_all_zero("abort_outputs");
        chk("abort_mem", 64'(mem[32'h20 >> 2]), 64'h12BB56DD);
        rst = 1'b0;
        @(posedge clk); #2;
        chk_all_zero("abort_post_outputs");
        drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
        #1;
        chk("abort_tie_m0", {62'd0, m1_gnt_o, m0_gnt_o}, 64'b01);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port word RAM peripheral between two bus masters: m0 (core load/store unit) and m1 (debug/DMA master).
- Arbitrates requests round-robin and sequences each RAM access.
- The RAM only supports full-word writes, so the block performs read-modify-write for byte-enable writes.
- Sits between the bus masters and the RAM; the RAM has a combinational read port and a registered write.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width (byte enables = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
m0_req_i  in  1  m0 request; held until granted
m0_we_i  in  1  m0 write (1) / read (0)
m0_be_i  in  DATA_W/8  m0 byte enables (writes only)
m0_addr_i  in  ADDR_W  m0 byte address
m0_wdata_i  in  DATA_W  m0 write data
m0_gnt_o  out  1  m0 request accepted this cycle
m0_rvalid_o  out  1  m0 response valid (read data, or write acknowledge)
m0_rdata_o  out  DATA_W  m0 read data
m1_*  same set as m0_* for master 1
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_W  RAM byte address, bits [1:0] forced to 0
ram_wdata_o  out  DATA_W  RAM write data
ram_rdata_i  in  DATA_W  RAM read data (combinational from ram_addr_o)

Behaviour:
- Reset: clk and rst as decided; rst is synchronous, active-high. While rst=1 and in the first cycle after it, all outputs are 0: gnt, rvalid, rdata, ram_we, ram_addr, ram_wdata. State becomes IDLE. last_grant is set to m1, so m0 wins the first tie.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - If any req is high, pick a winner. If only one requests, it wins. If both request, the master not in last_grant wins.
  - Assert the winner's gnt for exactly one cycle (combinational from state and req; gated 0 under rst).
  - Latch we, be, addr, wdata and master id. Update last_grant.
  - Next state: RD if read or partial write (be neither all-ones nor zero). WR if full write. RESP if write with be=0 (no RAM write).
- RD: ram_addr_o = {addr[ADDR_W-1:2],2'b00}, ram_we_o=0.
  - Read: capture ram_rdata_i into the response register; go to RESP.
  - Partial write: build merged = per byte lane, be ? wdata : ram_rdata_i; go to WR.
- WR: ram_we_o=1, ram_addr_o aligned as above, ram_wdata_o = wdata (full write) or merged (partial write). The RAM commits at the end of this cycle. Go to RESP.
- RESP: the owner's rvalid=1 for exactly one cycle. rdata is the captured word for reads and 0 for writes. The other master sees rvalid=0. Go to IDLE.
- RESP does not grant. The earliest next grant is the cycle after RESP, so the arbiter handles one transaction at a time.
- Latency in cycles from gnt to rvalid: read 2, full write 2, partial write 3, be=0 write 1.
- Outside WR, ram_we_o=0. Outside RD and WR, ram_addr_o and ram_wdata_o hold their last value.
- rdata holds its value when rvalid=0. It is not required to be meaningful then.
- Inputs must stay stable while req=1 and gnt=0. They are sampled only in the grant cycle and may change afterwards.
- A master asserting req in RESP or during another master's transaction waits. Round-robin guarantees service within one transaction of the competitor.
- Address bits [1:0] are ignored; no misalignment error is raised.
- rst mid-transaction aborts: no RAM write occurs in the cycle after rst is asserted, no rvalid is issued for the aborted transaction, and state returns to IDLE.

Decomposition:
- Shared package/defines: state encodings (IDLE, RD, WR, RESP), BE_FULL constant, master-id constants M0/M1.
- Sub-module rr_arb2: two-request round-robin arbiter.
  - Inputs: req[1:0], update strobe, rst.
  - Output: one-hot gnt[1:0].
  - Holds last_grant internally.

Test Plan:
- Read after reset: preload RAM[0x10]=0xDEADBEEF; m0 read addr 0x10 -> m0_gnt 1 cycle, m0_rvalid 2 cycles later with rdata 0xDEADBEEF, ram_we never asserted.
- Full write: m1 write addr 0x20, be=4'hF, wdata 0x12345678 -> one WR cycle with ram_we=1, ram_addr=0x20, ram_wdata=0x12345678; m1_rvalid next cycle; readback gives 0x12345678.
- Partial RMW: RAM[0x20]=0x12345678; m0 write be=4'b0101, wdata 0xAABBCCDD -> ram_wdata=0x12BB56DD; rvalid 3 cycles after gnt.
- Contention: both req continuously from reset -> grants alternate m0, m1, m0, m1; each gnt is separated by a full transaction; no overlapping rvalid.
- Edge cases: write be=0 -> rvalid 1 cycle after gnt, no ram_we. Address 0x23 -> ram_addr 0x20.
- Reset mid-op: assert rst during RD of a partial write -> no ram_we, no rvalid; all outputs 0; next request is granted normally with m0 priority on a tie.
